// File: rtl/img_pkg.sv
// Shared image-pipeline types: pixel type, frame-reader FSM states and the
// output FIFO entry layout (markers travel alongside each pixel).
package img_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PIX_FIFO_DEPTH = 3;
  localparam int PIX_CNT_W      = 2;

  typedef struct packed {
    logic   sof;
    logic   eol;
    logic   eof;
    pixel_t data;
  } pix_entry_t;

endpackage

// File: rtl/pix_fifo.sv
// 3-entry shift FIFO; entry 0 is the registered head, vacated slots read as zero
// so the outputs are all-zero whenever the FIFO is empty.
module pix_fifo
  import img_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  pix_entry_t           i_din,
  output pix_entry_t           o_dout,
  output logic [PIX_CNT_W-1:0] o_count
);

  pix_entry_t           r_q [PIX_FIFO_DEPTH];
  pix_entry_t           w_q_next [PIX_FIFO_DEPTH];
  logic [PIX_CNT_W-1:0] r_count;
  logic [PIX_CNT_W-1:0] w_count_next;
  logic [PIX_CNT_W-1:0] w_wr_idx;
  logic                 w_pop;
  logic                 w_push;

  assign w_pop    = i_pop && (r_count != '0);
  assign w_push   = i_push && ((r_count != PIX_CNT_W'(PIX_FIFO_DEPTH)) || w_pop);
  assign w_wr_idx = r_count - {{(PIX_CNT_W-1){1'b0}}, w_pop};

  always_comb begin
    for (int i = 0; i < PIX_FIFO_DEPTH; i++) begin
      w_q_next[i] = r_q[i];
    end
    if (w_pop) begin
      for (int i = 0; i < PIX_FIFO_DEPTH - 1; i++) begin
        w_q_next[i] = r_q[i+1];
      end
      w_q_next[PIX_FIFO_DEPTH-1] = '0;
    end
    // Push lands just behind the surviving entries, after any shift.
    if (w_push) begin
      w_q_next[w_wr_idx] = i_din;
    end
    w_count_next = r_count + {{(PIX_CNT_W-1){1'b0}}, w_push}
                           - {{(PIX_CNT_W-1){1'b0}}, w_pop};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      for (int i = 0; i < PIX_FIFO_DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_count <= w_count_next;
      for (int i = 0; i < PIX_FIFO_DEPTH; i++) begin
        r_q[i] <= w_q_next[i];
      end
    end
  end

  assign o_dout  = r_q[0];
  assign o_count = r_count;

endmodule

// File: rtl/frame_reader.sv
// Raster-order frame reader: streams IMG_W x IMG_H pixels from a 1-cycle-latency
// RAM through a small FIFO with SOF/EOL/EOF markers and valid/ready handshake.
module frame_reader
  import img_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_rdata,
  output logic [7:0]        o_pix_data,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic              o_pix_sof,
  output logic              o_pix_eol,
  output logic              o_pix_eof
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [XW-1:0]     X_ONE  = XW'(1);
  localparam logic [YW-1:0]     Y_ONE  = YW'(1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

  state_t               r_state;
  state_t               w_state_next;
  logic [ADDR_W-1:0]    r_addr;
  logic [XW-1:0]        r_x;
  logic [YW-1:0]        r_y;
  logic                 r_inflight;
  logic [2:0]           r_mark;
  logic [2:0]           w_mark;
  logic                 w_issue;
  logic                 w_pop;
  logic [PIX_CNT_W-1:0] w_count;
  pix_entry_t           w_head;
  pix_entry_t           w_din;

  // Credit check uses only registered state, so pix_ready never reaches the RAM port.
  assign w_issue = (r_state == READ) &&
                   (({1'b0, w_count} + {{PIX_CNT_W{1'b0}}, r_inflight}) <
                    (PIX_CNT_W+1)'(PIX_FIFO_DEPTH));

  assign w_mark[2] = (r_x == '0) && (r_y == '0);
  assign w_mark[1] = (r_x == X_LAST);
  assign w_mark[0] = (r_x == X_LAST) && (r_y == Y_LAST);

  assign w_din = '{sof: r_mark[2], eol: r_mark[1], eof: r_mark[0], data: i_mem_rdata};

  pix_fifo u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_count (w_count)
  );

  assign o_pix_valid = (w_count != '0);
  assign w_pop       = o_pix_valid && i_pix_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = READ;
      READ:    if (w_issue && (r_addr == A_LAST)) w_state_next = DRAIN;
      DRAIN:   if (w_pop && w_head.eof) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_inflight <= 1'b0;
      r_mark     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_issue;
      r_mark     <= w_mark;
      if (r_state == DONE) begin
        r_addr <= '0;
        r_x    <= '0;
        r_y    <= '0;
      end else if (w_issue) begin
        r_addr <= r_addr + A_ONE;
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= r_y + Y_ONE;
        end else begin
          r_x <= r_x + X_ONE;
        end
      end
    end
  end

  assign o_busy      = (r_state == READ) || (r_state == DRAIN);
  assign o_done      = (r_state == DONE);
  assign o_mem_rd_en = w_issue;
  assign o_mem_addr  = r_addr;
  assign o_pix_data  = w_head.data;
  assign o_pix_sof   = w_head.sof;
  assign o_pix_eol   = w_head.eol;
  assign o_pix_eof   = w_head.eof;

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader on a 4x2 frame; RAM address k holds 8'h10+k.
module tb_frame_reader;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic          busy, done, rd_en, valid, sof, eol, eof;
  logic [AW-1:0] addr;
  logic [7:0]    rdata = 8'h00;
  logic [7:0]    data;

  int n_assert = 0;
  int n_fail   = 0;

  frame_reader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .o_mem_rd_en (rd_en),
    .o_mem_addr  (addr),
    .i_mem_rdata (rdata),
    .o_pix_data  (data),
    .o_pix_valid (valid),
    .i_pix_ready (ready),
    .o_pix_sof   (sof),
    .o_pix_eol   (eol),
    .o_pix_eof   (eof)
  );

  always #5 clk = ~clk;

  // Frame-buffer RAM model with 1-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rdata <= 8'h10 + addr[7:0];
  end

  // Transfer/read monitor sampled on the falling edge.
  logic [10:0]   xfer_q[$];
  logic [AW-1:0] rd_q[$];
  int            n_done = 0, n_reads = 0, n_xfer = 0, n_ovf = 0, n_unstable = 0;
  logic          prev_stall = 1'b0;
  logic [10:0]   prev_word = '0;

  always @(negedge clk) begin
    if (prev_stall && !(valid && ({sof, eol, eof, data} == prev_word))) n_unstable++;
    if (rd_en && ((n_reads - n_xfer) >= 3)) n_ovf++;
    if (valid && ready) begin
      xfer_q.push_back({sof, eol, eof, data});
      n_xfer++;
    end
    if (rd_en) begin
      rd_q.push_back(addr);
      n_reads++;
    end
    if (done) n_done++;
    prev_stall = valid && !ready;
    prev_word  = {sof, eol, eof, data};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] exp_word(input int k);
    logic [7:0] d;
    d = 8'h10 + 8'(k);
    return {k == 0, (k % W) == W - 1, k == W * H - 1, d};
  endfunction

  function automatic logic [26:0] out_vec();
    return {busy, done, rd_en, addr, data, valid, sof, eol, eof};
  endfunction

  task automatic clear_mon();
    xfer_q.delete();
    rd_q.delete();
    n_done = 0; n_reads = 0; n_xfer = 0; n_ovf = 0; n_unstable = 0;
    prev_stall = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (n_done != 0) break;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_len"}, xfer_q.size(), W * H);
    for (int k = 0; k < W * H; k++) begin
      check($sformatf("%s_pix%0d", tag, k), (k < xfer_q.size()) ? xfer_q[k] : 11'h7ff, exp_word(k));
    end
    check({tag, "_done_cnt"}, n_done, 1);
    check({tag, "_reads"}, n_reads, W * H);
    check({tag, "_overrun"}, n_ovf, 0);
    check({tag, "_unstable"}, n_unstable, 0);
  endtask

  initial begin
    // 1: reset and idle
    repeat (2) @(negedge clk);
    check("in_reset_outputs", out_vec(), 27'd0);
    @(posedge clk); #1 rst = 1'b0;
    clear_mon();
    repeat (5) @(negedge clk);
    check("idle_outputs", out_vec(), 27'd0);
    #1 check("idle_reads", n_reads, 0);

    // 2: full-rate frame with cycle-exact timing
    clear_mon();
    ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("t2_busy_n", busy, 1'b1);
    check("t2_rden_n", rd_en, 1'b1);
    check("t2_addr_n", addr, 0);
    check("t2_valid_n", valid, 1'b0);
    @(negedge clk);
    check("t2_valid_n1", valid, 1'b0);
    check("t2_addr_n1", addr, 1);
    for (int k = 0; k < W * H; k++) begin
      @(negedge clk);
      check($sformatf("t2_valid_%0d", k), valid, 1'b1);
      check($sformatf("t2_word_%0d", k), {sof, eol, eof, data}, exp_word(k));
      check($sformatf("t2_done_%0d", k), done, 1'b0);
    end
    @(negedge clk);
    check("t2_done_pulse", done, 1'b1);
    check("t2_busy_low", busy, 1'b0);
    check("t2_valid_low", valid, 1'b0);
    @(negedge clk);
    check("t2_done_end", done, 1'b0);
    check("t2_idle_outputs", out_vec(), 27'd0);
    #1 check_frame("t2");

    // 3: seeded random backpressure
    clear_mon();
    void'($urandom(32'd2024));
    ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      case (i)
        0, 3:    ready = 1'b1;
        1, 2:    ready = 1'b0;
        default: ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk); #1;
      if (n_done != 0) break;
      @(posedge clk); #1;
    end
    ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_frame("t3");

    // 4: held backpressure fills the FIFO with exactly 3 reads
    clear_mon();
    ready = 1'b0;
    pulse_start();
    repeat (9) @(negedge clk);
    #1;
    check("t4_reads", n_reads, 3);
    check("t4_addrs", {rd_q.size() > 2 ? rd_q[0] : 12'hfff,
                       rd_q.size() > 2 ? rd_q[1] : 12'hfff,
                       rd_q.size() > 2 ? rd_q[2] : 12'hfff}, {12'd0, 12'd1, 12'd2});
    check("t4_hold_data", data, 8'h10);
    check("t4_hold_valid", valid, 1'b1);
    check("t4_hold_rden", rd_en, 1'b0);
    @(posedge clk); #1 ready = 1'b1;
    wait_done(50);
    check_frame("t4");

    // 5: start re-pulsed mid-frame is ignored
    clear_mon();
    ready = 1'b1;
    pulse_start();
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(negedge clk);
    #1 check_frame("t5");

    // 6: asynchronous reset after the 3rd transfer, then a clean frame
    clear_mon();
    ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (n_xfer >= 3) break;
    end
    check("t6_xfers_seen", n_xfer, 3);
    @(posedge clk); #2 rst = 1'b1;
    #1 check("t6_async_outputs", out_vec(), 27'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
    pulse_start();
    wait_done(50);
    check("t6_first_addr", (rd_q.size() > 0) ? rd_q[0] : 12'hfff, 0);
    check_frame("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/frame_reader.md
# frame_reader

Raster-order pixel source for the image pipeline's streaming filters. On a `start` pulse it reads one IMG_W×IMG_H frame of 8-bit pixels from a synchronous frame-buffer RAM with 1-cycle read latency. It emits the pixels with a valid/ready handshake and start-of-frame, end-of-line and end-of-frame markers. A 3-entry output FIFO absorbs read latency and downstream backpressure, sustaining 1 pixel/clock with no combinational path from `pix_ready` to the RAM port.

## Interface
- IMG_W, 64: pixels per line (≥2)
- IMG_H, 64: lines per frame (≥1)
- ADDR_W, 12: RAM address width; IMG_W*IMG_H ≤ 2^ADDR_W
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from the cycle after `start` is accepted until `done`
- done  out  1  single-cycle pulse after the last pixel is accepted
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address, row-major (y*IMG_W + x)
- mem_rdata  in  8  RAM data, valid the cycle after `mem_rd_en`
- pix_data  out  8  output pixel
- pix_valid  out  1  `pix_data` and markers are valid
- pix_ready  in  1  downstream accepts; transfer = valid & ready
- pix_sof  out  1  pixel (0,0)
- pix_eol  out  1  pixel x = IMG_W-1
- pix_eof  out  1  pixel (IMG_W-1, IMG_H-1)

## Operation
- States: IDLE → READ (start=1) → DRAIN (last address issued) → DONE (last pixel transferred) → IDLE (unconditional, 1 cycle).
- IDLE: all outputs 0 except `mem_addr`, which holds its value. `start` in any other state is ignored.
- READ: issue `mem_rd_en` when fifo_count + inflight < 3. inflight = 1 if a read was issued in the previous cycle. The address counter increments by 1 per issued read. x/y counters travel with each read, and the markers are computed from them at issue time.
- After the read at address IMG_W*IMG_H-1 is issued, go to DRAIN. No further reads.
- Returning `mem_rdata` and its 3 marker bits are written into the FIFO (11-bit entries) in the cycle after issue. The FIFO head drives `pix_*`. A pop occurs on valid & ready.
- FIFO never overflows by construction; push and pop in the same cycle leave the count unchanged.
- `pix_valid` may only deassert after a transfer. Data and markers stay stable while valid & !ready.
- DONE: `done`=1 for 1 cycle, `busy`=0, counters cleared.
- The address is unsigned with no wrap. IMG_W=1 is unsupported.
- Reset mid-frame: all state, counters and FIFO cleared immediately. Any RAM data in flight is discarded. The next frame starts at address 0.

## Timing
- Reset values: busy, done, mem_rd_en, mem_addr, pix_data, pix_valid, pix_sof, pix_eol and pix_eof are all 0.
- `start` sampled at edge N:
  - edge N: `busy` and `mem_rd_en` go high with address 0.
  - edge N+1: `mem_rdata` is valid in the cycle that follows.
  - edge N+2: `pix_valid` rises with the (0,0) pixel.
- Startup latency is therefore 2 cycles from accepted `start` to first `pix_valid`.
- With `pix_ready` held high: one transfer per clock, IMG_W*IMG_H consecutive cycles, no bubbles.
- Last transfer at edge M: `done` high during cycle M..M+1 and `busy` low from edge M. A new `start` is accepted from edge M+2 (IDLE).
- When `pix_ready` rises after a stall, transfers resume the same cycle from the FIFO. Reads resume the cycle after the count drops.

## Structure
- Shared package `img_pkg`: state enum {IDLE, READ, DRAIN, DONE} and constant PIX_FIFO_DEPTH = 3. Reuse the existing 8-bit pixel type.
- Sub-module `pix_fifo`: 3-entry, 11-bit-wide synchronous FIFO.
  - Ports: push, pop, din, dout, count.
  - Registered head output, reset to empty.
- Top module contains the FSM, address/x/y counters, inflight flag and marker generation.

## Test plan
Use IMG_W=4, IMG_H=2, with RAM preloaded so address k holds 8'h10+k.
1. Reset release, idle 5 cycles → all outputs 0, no `mem_rd_en`.
2. `start` pulse, `pix_ready`=1 → `pix_valid` 2 cycles after `start`; data 10..17 in 8 consecutive cycles.
   - `pix_sof` on 8'h10; `pix_eol` on 8'h13 and 8'h17; `pix_eof` on 8'h17.
   - `done` pulse 1 cycle after the 8'h17 transfer.
3. `pix_ready` toggling 1,0,0,1… (random, seeded) → same 8-pixel ordered sequence with no loss or duplication. Data is stable during stalls, `mem_rd_en` stops when the FIFO holds 3, and the FIFO count never exceeds 3.
4. `pix_ready`=0 for 10 cycles from start → exactly 3 reads issued (addr 0-2), `pix_data` holds 8'h10; after release, the frame completes correctly.
5. `start` re-pulsed mid-frame → ignored; single 8-pixel frame, single `done`.
6. `rst` asserted after the 3rd transfer → outputs 0 asynchronously; the next `start` yields 10..17 from address 0.
